// File: rtl/single_fp_pkg.sv
// single_fp_pkg: shared 24-bit float format constants and FSM states.
// Format: sign [23], exponent [22:16] (bias 63), fraction [15:0].
package single_fp_pkg;

  localparam int EXP_W     = 7;
  localparam int FRAC_W    = 16;
  localparam int WORD_W    = 1 + EXP_W + FRAC_W;
  localparam int BIAS      = 63;
  localparam int EXP_MAX   = 127;
  localparam int DIV_STEPS = 19;

  localparam logic [WORD_W-1:0] QNAN = 24'h7F8000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVIDE,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/single_div_core.sv
// single_div_core: restoring significand divider, one quotient bit
// per cycle for DIV_STEPS cycles after load; sticky = OR of remainder.
module single_div_core
  import single_fp_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [FRAC_W:0]   dvd,
  input  logic [FRAC_W:0]   dvs,
  output logic              last,
  output logic [DIV_STEPS-1:0] quot,
  output logic              sticky
);

  logic [FRAC_W+1:0]    rem_q, rem_d;
  logic [FRAC_W:0]      dvs_q;
  logic [DIV_STEPS-1:0] quot_q;
  logic [4:0]           cnt_q;

  logic                 ge;
  logic [FRAC_W+1:0]    r_next;

  // One restoring step: subtract if it fits, then shift remainder.
  always_comb begin
    ge     = rem_q >= {1'b0, dvs_q};
    r_next = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    rem_d  = r_next << 1;
  end

  // Load operands, then iterate until the step counter drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= {1'b0, dvd};
      dvs_q  <= dvs;
      quot_q <= '0;
      cnt_q  <= 5'(DIV_STEPS);
    end else if (cnt_q != 5'd0) begin
      rem_q  <= rem_d;
      quot_q <= {quot_q[DIV_STEPS-2:0], ge};
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign last   = (cnt_q == 5'd1);
  assign quot   = quot_q;
  assign sticky = |rem_q;

endmodule

// File: rtl/single_div.sv
// single_div: 24-bit float divider with fixed 21-cycle latency.
// Define SINGLE_DIV_FLAGS_EN to add div_by_zero / invalid outputs.
module single_div
  import single_fp_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] operand1,
  input  logic [WORD_W-1:0] operand2,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] output_final
`ifdef SINGLE_DIV_FLAGS_EN
  ,
  output logic              div_by_zero,
  output logic              invalid
`endif
);

  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(EXP_MAX);
  localparam logic signed [8:0] EMAX_S = 9'(EXP_MAX);

  state_e state_q, state_d;
  logic [WORD_W-1:0] op1_q, op2_q;
  logic [WORD_W-1:0] res_q, res_d;
  logic              done_q, done_d;
  logic              accept;

  logic                 last;
  logic [DIV_STEPS-1:0] quot;
  logic                 sticky;

  assign accept = start & (state_q == S_IDLE);

  single_div_core u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .dvd    ({1'b1, operand1[FRAC_W-1:0]}),
    .dvs    ({1'b1, operand2[FRAC_W-1:0]}),
    .last   (last),
    .quot   (quot),
    .sticky (sticky)
  );

  // Sequencing: IDLE -> DIVIDE -> NORM -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_DIVIDE;
      S_DIVIDE: if (last) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  logic              s1, s2, sign;
  logic [EXP_W-1:0]  e1, e2;
  logic [FRAC_W-1:0] f1, f2;
  logic              z1, z2, i1, i2, n1, n2;

  assign {s1, e1, f1} = op1_q;
  assign {s2, e2, f2} = op2_q;
  assign sign = s1 ^ s2;
  assign z1 = (e1 == '0);
  assign z2 = (e2 == '0);
  assign i1 = (e1 == EXP_ONES) & (f1 == '0);
  assign i2 = (e2 == EXP_ONES) & (f2 == '0);
  assign n1 = (e1 == EXP_ONES) & (f1 != '0);
  assign n2 = (e2 == EXP_ONES) & (f2 != '0);

  logic              q_msb, grd, stk, rnd_up;
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W:0]   frac_r;
  logic [8:0]        exp_n;
  logic              ovf, unf;
  logic              res_nan, res_dbz;

  // Normalise the raw quotient, round to nearest even, form exponent.
  always_comb begin
    q_msb  = quot[DIV_STEPS-1];
    frac   = q_msb ? quot[17:2] : quot[16:1];
    grd    = q_msb ? quot[1] : quot[0];
    stk    = q_msb ? (quot[0] | sticky) : sticky;
    rnd_up = grd & (stk | frac[0]);
    frac_r = {1'b0, frac} + {{FRAC_W{1'b0}}, rnd_up};
    exp_n  = {2'b00, e1} - {2'b00, e2} + 9'(BIAS)
           - {8'd0, ~q_msb} + {8'd0, frac_r[FRAC_W]};
    ovf    = $signed(exp_n) >= EMAX_S;
    unf    = $signed(exp_n) <= 9'sd0;
  end

  // Special operands take precedence over the arithmetic result.
  always_comb begin
    res_nan = n1 | n2 | (z1 & z2) | (i1 & i2);
    res_dbz = z2 & ~res_nan;
    res_d   = {sign, exp_n[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    if (res_nan)
      res_d = QNAN;
    else if (z2 | i1)
      res_d = {sign, EXP_ONES, {FRAC_W{1'b0}}};
    else if (i2 | z1)
      res_d = {sign, {(WORD_W-1){1'b0}}};
    else if (ovf)
      res_d = {sign, EXP_ONES, {FRAC_W{1'b0}}};
    else if (unf)
      res_d = {sign, {(WORD_W-1){1'b0}}};
  end

  assign done_d = (state_q == S_NORM);

  // Control state and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      res_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (done_d) res_q <= res_d;
      if (accept) begin
        op1_q <= operand1;
        op2_q <= operand2;
      end
    end
  end

`ifdef SINGLE_DIV_FLAGS_EN
  logic dbz_q, inv_q;

  // Flags follow the result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbz_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (done_d) begin
      dbz_q <= res_dbz;
      inv_q <= res_nan;
    end
  end

  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;
`endif

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign output_final = res_q;

endmodule

// File: tb/tb_single_div.sv
// tb_single_div: directed vectors against an arithmetic reference
// model of the 24-bit float divider and its 21-cycle timing.
module tb_single_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] operand1;
  logic [23:0] operand2;
  logic        busy;
  logic        done;
  logic [23:0] output_final;
`ifdef SINGLE_DIV_FLAGS_EN
  logic        div_by_zero;
  logic        invalid;
`endif

  single_div dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .operand1     (operand1),
    .operand2     (operand2),
    .busy         (busy),
    .done         (done),
    .output_final (output_final)
`ifdef SINGLE_DIV_FLAGS_EN
    ,
    .div_by_zero  (div_by_zero),
    .invalid      (invalid)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  task automatic check(input string nm,
                       input logic [23:0] act,
                       input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Quotient from exact rational arithmetic with RNE rounding.
  function automatic logic [23:0] model(input logic [23:0] a,
                                        input logic [23:0] b);
    int     e1, e2, e, k;
    longint m1, m2, num, q, r;
    bit     s, z1, z2, i1, i2, n1, n2;
    logic [6:0]  ef;
    logic [15:0] ff;
    e1 = int'(a[22:16]);
    e2 = int'(b[22:16]);
    s  = a[23] ^ b[23];
    z1 = (e1 == 0);
    z2 = (e2 == 0);
    i1 = (e1 == 127) && (a[15:0] == 0);
    i2 = (e2 == 127) && (b[15:0] == 0);
    n1 = (e1 == 127) && (a[15:0] != 0);
    n2 = (e2 == 127) && (b[15:0] != 0);
    if (n1 || n2 || (z1 && z2) || (i1 && i2)) return 24'h7F8000;
    if (z2 || i1) return {s, 23'h7F0000};
    if (i2 || z1) return {s, 23'h0};
    m1 = 65536 + longint'(a[15:0]);
    m2 = 65536 + longint'(b[15:0]);
    k  = (m1 < m2) ? 1 : 0;
    num = m1 << (16 + k);
    q = num / m2;
    r = num % m2;
    if ((2 * r > m2) || ((2 * r == m2) && (q % 2 == 1))) q++;
    e = e1 - e2 + 63 - k;
    if (q == 131072) begin
      q = 65536;
      e++;
    end
    if (e >= 127) return {s, 23'h7F0000};
    if (e <= 0) return {s, 23'h0};
    ef = 7'(e);
    ff = 16'(q);
    return {s, ef, ff};
  endfunction

  // Expected outputs: accept when idle, done 20 edges later.
  logic        m_busy, m_done;
  logic [23:0] m_out, m_pend;
  int          m_age;

  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 0;
      m_done <= 0;
      m_out  <= '0;
      m_age  <= 0;
    end else if (!m_busy) begin
      m_done <= 0;
      if (start) begin
        m_busy <= 1;
        m_age  <= 1;
        m_pend <= model(operand1, operand2);
      end
    end else begin
      m_age  <= m_age + 1;
      m_done <= (m_age == 20);
      if (m_age == 20) m_out <= m_pend;
      if (m_age == 21) m_busy <= 0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", {23'd0, busy}, {23'd0, m_busy});
      check("done", {23'd0, done}, {23'd0, m_done});
      check("out", output_final, m_out);
    end
  end

  task automatic do_div(input logic [23:0] a,
                        input logic [23:0] b,
                        input logic [23:0] lit,
                        input bit          use_lit);
    int n;
    @(posedge clock); #1;
    operand1 = a;
    operand2 = b;
    start    = 1;
    @(posedge clock); #1;
    start = 0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency", 24'(n + 1), 24'd21);
    if (use_lit) begin
      check("model_lit", model(a, b), lit);
      check("result", output_final, lit);
    end
    @(posedge clock); #1;
    check("busy_after", {23'd0, busy}, 24'd0);
    check("done_after", {23'd0, done}, 24'd0);
  endtask

  int ndone;

  initial begin
    clock    = 0;
    reset    = 1;
    start    = 0;
    operand1 = '0;
    operand2 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1;
    check("rst_busy", {23'd0, busy}, 24'd0);
    check("rst_done", {23'd0, done}, 24'd0);
    check("rst_out", output_final, 24'd0);
    reset = 0;

    do_div(24'h418000, 24'h408000, 24'h400000, 1);
    do_div(24'h3F0000, 24'h408000, 24'h3D5555, 1);
    do_div(24'hBF0000, 24'h3F0000, 24'hBF0000, 1);
    do_div(24'h414000, 24'h408000, 24'h3FAAAB, 1);
    do_div(24'h3F0000, 24'h000000, 24'h7F0000, 1);
`ifdef SINGLE_DIV_FLAGS_EN
    check("dbz", {23'd0, div_by_zero}, 24'd1);
`endif
    do_div(24'h000000, 24'h000000, 24'h7F8000, 1);
`ifdef SINGLE_DIV_FLAGS_EN
    check("inv", {23'd0, invalid}, 24'd1);
`endif
    do_div(24'h010000, 24'h7E0000, 24'h000000, 1);
    do_div(24'h7E0000, 24'h010000, 24'h7F0000, 1);
    do_div(24'h7F0000, 24'h3F0000, 24'h7F0000, 1);
    do_div(24'h3F0000, 24'hFF0000, 24'h800000, 1);
    do_div(24'h7F0001, 24'h3F0000, 24'h7F8000, 1);
    do_div(24'h7F0000, 24'hFF0000, 24'h7F8000, 1);
    do_div(24'h000000, 24'hBF0000, 24'h800000, 1);
    do_div(24'h3FFFFF, 24'h3F0001, 24'h0, 0);
    do_div(24'h4A1234, 24'hC5ABCD, 24'h0, 0);
    do_div(24'h3E7FFF, 24'h3F8000, 24'h0, 0);

    // Second start while busy must be ignored.
    @(posedge clock); #1;
    operand1 = 24'h418000;
    operand2 = 24'h408000;
    start    = 1;
    @(posedge clock); #1;
    start = 0;
    repeat (4) @(posedge clock);
    #1;
    operand1 = 24'h3F0000;
    operand2 = 24'h408000;
    start    = 1;
    @(posedge clock); #1;
    start = 0;
    ndone = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check("one_done", 24'(ndone), 24'd1);
    check("busy_res", output_final, 24'h400000);

    // Reset mid-operation abandons the division.
    @(posedge clock); #1;
    operand1 = 24'h3F0000;
    operand2 = 24'h408000;
    start    = 1;
    @(posedge clock); #1;
    start = 0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("mid_rst_busy", {23'd0, busy}, 24'd0);
    check("mid_rst_out", output_final, 24'd0);
    ndone = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done) ndone++;
    end
    check("no_done", 24'(ndone), 24'd0);
    do_div(24'h3F0000, 24'h408000, 24'h3D5555, 1);

    repeat (2) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
